// File: rtl/cp0_unit_pkg.sv
// ============================================================================
// Module      : cp0_unit_pkg
// Description : Shared CP0 register numbers, exception codes and handler entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_unit_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

`default_nettype wire

// File: rtl/cp0_unit_timer.sv
// ============================================================================
// Module      : cp0_timer
// Description : Count/Compare timer with a pending flag; used under CP0_TIMER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_timer
    import cp0_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        pending
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_pending <= 1'b0;
        end else begin
            if (wr_en && wr_addr == CP0_COUNT)
                r_count <= wr_data;
            else
                r_count <= r_count + 32'd1;

            // A Compare write acknowledges the timer interrupt.
            if (wr_en && wr_addr == CP0_COMPARE) begin
                r_compare <= wr_data;
                r_pending <= 1'b0;
            end else if (r_count == r_compare && r_compare != 32'd0) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign count   = r_count;
    assign compare = r_compare;
    assign pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/cp0_unit.sv
// ============================================================================
// Module      : cp0_unit
// Description : Coprocessor 0 - exception/interrupt request, SR/Cause/EPC/PRId.
//               Optional Count/Compare timer enabled by macro CP0_TIMER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h2022_0707
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic        w_timer_int;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [5:0]  w_hw_int;
    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic [31:0] w_epc_raw;
    logic [31:0] w_rd;

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (en & ~w_req),
        .wr_addr (CP0Add),
        .wr_data (CP0In),
        .count   (w_count),
        .compare (w_compare),
        .pending (w_timer_int)
    );
`else
    assign w_timer_int = 1'b0;
    assign w_count     = 32'd0;
    assign w_compare   = 32'd0;
`endif

    assign w_hw_int  = HWInt | {w_timer_int, 5'b0};
    assign w_int_req = (|(w_hw_int & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
    assign w_req     = ~reset & (w_int_req | w_exc_req);
    assign w_epc_raw = BDIn ? (VPC - 32'd4) : VPC;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im       <= 6'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= 6'd0;
            r_exc_code <= 5'd0;
            r_epc      <= 32'd0;
        end else begin
            r_ip <= w_hw_int;
            if (w_req) begin
                r_exl      <= 1'b1;
                r_bd       <= BDIn;
                r_exc_code <= w_int_req ? EXC_INT : ExcCodeIn;
                r_epc      <= {w_epc_raw[31:2], 2'b00};
            end else begin
                if (en) begin
                    if (CP0Add == CP0_SR) begin
                        r_im  <= CP0In[15:10];
                        r_exl <= CP0In[1];
                        r_ie  <= CP0In[0];
                    end else if (CP0Add == CP0_EPC) begin
                        r_epc <= {CP0In[31:2], 2'b00};
                    end
                end
                // eret clears EXL even over a same-cycle SR write.
                if (EXLClr)
                    r_exl <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd = 32'd0;
        case (CP0Add)
            CP0_SR:      w_rd = {16'd0, r_im, 8'd0, r_exl, r_ie};
            CP0_CAUSE:   w_rd = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};
            CP0_EPC:     w_rd = r_epc;
            CP0_PRID:    w_rd = PRID_VALUE;
            CP0_COUNT:   w_rd = w_count;
            CP0_COMPARE: w_rd = w_compare;
            default:     w_rd = 32'd0;
        endcase
    end

    assign CP0Out = w_rd;
    assign EPCOut = r_epc;
    assign Req    = w_req;

endmodule

`default_nettype wire

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor 0 for the P7 pipeline. It is the request side of the exception/interrupt flush protocol that the pipeline registers consume.
- Samples the macro-PC, branch-delay flag and exception code arriving at the M stage, together with the six hardware interrupt lines.
- Decides whether to take an exception or interrupt, raises Req for the pipeline flush, and records SR/Cause/EPC.
- Services mtc0/mfc0 register access and eret (EXL clear).

Parameters:
- PRID_VALUE, 32'h2022_0707, constant value returned when PRId (reg 15) is read.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  mtc0 write enable (M stage)
- CP0Add  input  5  CP0 register number for read/write
- CP0In  input  32  mtc0 write data
- CP0Out  output  32  mfc0 read data (combinational from registers)
- VPC  input  32  macro PC of the M-stage instruction
- BDIn  input  1  M-stage instruction is in a delay slot
- ExcCodeIn  input  5  M-stage exception code; 0 means none
- HWInt  input  6  external interrupt lines, level sensitive
- EXLClr  input  1  eret in M stage
- EPCOut  output  32  current EPC, used by eret redirect
- Req  output  1  take exception/interrupt now (combinational); flushes all pipeline registers and redirects PC to 0x4180

Behaviour:
- Registers:
  - SR (12): IM = bits[15:10], EXL = bit[1], IE = bit[0]; all other bits read 0.
  - Cause (13): BD = bit[31], IP = bits[15:10], ExcCode = bits[6:2]; read-only to mtc0.
  - EPC (14): read/write.
  - PRId (15): constant PRID_VALUE.
  - Any other address reads 0.
- Reset (sync, next rising edge with reset=1): SR=0, Cause=0, EPC=0. With reset asserted, Req=0 regardless of inputs. Reset takes priority over every other event.
- Request logic (combinational, same cycle):
  - IntReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL
  - ExcReq = (ExcCodeIn != 0) & !SR.EXL
  - Req = IntReq | ExcReq
- On the rising edge with Req=1:
  - EXL <= 1.
  - BD <= BDIn.
  - ExcCode <= IntReq ? 0 : ExcCodeIn. Interrupt has priority over a simultaneous exception.
  - EPC <= (BDIn ? VPC - 4 : VPC) with bits[1:0] forced 0.
- Cause.IP <= HWInt on every non-reset edge, independent of Req.
- EXLClr=1 and Req=0: EXL <= 0 on the edge.
- en=1, Req=0: CP0Add 12 writes SR's IM/EXL/IE fields from CP0In; CP0Add 14 writes EPC with bits[1:0] forced 0. Writes to any other address are ignored.
- Simultaneous events:
  - Req with en: the mtc0 write is discarded.
  - Req with EXLClr: Req wins, EXL ends at 1.
  - EXLClr with en to SR: the mtc0 value is written, then EXL is forced to 0.
- Read timing: reads observe register state before the edge. No internal write-to-read bypass; mtc0/mfc0 ordering is handled by the pipeline stall logic.
- Latency: Req has zero cycles of latency. State updates are visible one cycle after the triggering edge.

Optional Feature:
- Macro: CP0_TIMER_EN.
- When defined:
  - Adds Count (reg 9) and Compare (reg 11), both reset to 0.
  - Count increments by 1 every cycle with wrap at 2^32; mtc0 to reg 9 loads it instead.
  - A timer-pending flag sets when Count == Compare (and Compare != 0). An mtc0 to reg 11 clears the flag.
  - The flag is ORed into HWInt[5] for both IntReq and Cause.IP[15].
- When undefined: regs 9 and 11 read 0 and writes to them are ignored; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - register numbers CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15, CP0_COUNT=9, CP0_COMPARE=11;
  - ExcCode constants INT=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12;
  - handler entry address 32'h0000_4180.
- Optional sub-module cp0_timer (Count/Compare/pending flag), instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset, then write SR=32'h0000_FC01 via en/CP0Add=12 → CP0Out at CP0Add=12 reads 32'h0000_FC01; Req=0 while HWInt=0.
- VPC=32'h0000_3010, ExcCodeIn=10, BDIn=0 → Req=1 same cycle. Next cycle: EPC=32'h3010, Cause=32'h0000_0028, SR.EXL=1. Repeating the exception with EXL=1 → Req=0.
- SR=32'h0000_0401, HWInt=6'b000001, VPC=32'h3024, BDIn=1, ExcCodeIn=12 together → Req=1. Next: ExcCode=0, BD=1, EPC=32'h3020, Cause.IP[10]=1.
- EXL=1, EXLClr=1 → EXL=0 next cycle. EXLClr with Req → EXL stays 1. en to EPC (32'h3333) with Req → EPC = trapped VPC, not 32'h0000_3330.
- Reset asserted mid-exception (ExcCodeIn=4) → Req=0, and SR/Cause/EPC=0 after the edge.
- CP0_TIMER_EN: Compare=5, SR=32'h0000_8001, Count=0 → Req rises when Count reaches 5. Writing Compare clears the pending flag and Req.
